// File: rtl/ssd_scan_ctrl.sv
// N-digit seven-segment scan controller: prescaled digit scanning,
// frame-synchronous data commit, leading-zero blanking, 16-step brightness.
module ssd_scan_ctrl #(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned SCAN_DIV   = 100000,
   parameter int unsigned CNT_W      = 17
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    blank_lz,
   input  logic [3:0]              duty,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp_n,
   output logic                    frame_done
);

   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned DW    = 4 * NUM_DIGITS;
   localparam int unsigned PW    = CNT_W + 5;

   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [PW-1:0]    SCAN_DIV_P = PW'(SCAN_DIV);

   // scan position
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  fd_q, fd_d;
   // staging copy written by load
   logic [DW-1:0]         stg_digits_q, stg_digits_d;
   logic [NUM_DIGITS-1:0] stg_dp_q, stg_dp_d;
   logic [NUM_DIGITS-1:0] stg_en_q, stg_en_d;
   logic                  pend_q, pend_d;
   // active copy shown on the display
   logic [DW-1:0]         act_digits_q, act_digits_d;
   logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
   logic [NUM_DIGITS-1:0] act_en_q, act_en_d;
   // registered pin drivers
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_n_q, dp_n_d;

   logic                  slot_end_c;
   logic                  wrap_c;
   logic [NUM_DIGITS-1:0] blank_c;
   logic                  zero_run_c;
   logic [3:0]            sel_nib_c;
   logic                  sel_dp_c;
   logic                  sel_en_c;
   logic                  sel_blank_c;
   logic                  duty_on_c;
   logic                  lit_c;

   // Active-low hex decode, segment order {a,b,c,d,e,f,g}
   function automatic logic [6:0] hex7(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   // Prescaler and digit index; frame_done registers the wrap cycle
   always_comb begin
      slot_end_c = (cnt_q == CNT_LAST);
      wrap_c     = slot_end_c && (idx_q == IDX_LAST);
      cnt_d      = cnt_q + CNT_W'(1);
      idx_d      = idx_q;
      fd_d       = wrap_c;
      if (slot_end_c) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
   end

   // Staging capture and tear-free commit at frame wrap (load bypasses staging)
   always_comb begin
      stg_digits_d = stg_digits_q;
      stg_dp_d     = stg_dp_q;
      stg_en_d     = stg_en_q;
      pend_d       = pend_q;
      act_digits_d = act_digits_q;
      act_dp_d     = act_dp_q;
      act_en_d     = act_en_q;
      if (load) begin
         stg_digits_d = digits;
         stg_dp_d     = dp_in;
         stg_en_d     = digit_en;
         pend_d       = 1'b1;
      end
      if (wrap_c && (pend_q || load)) begin
         act_digits_d = load ? digits   : stg_digits_q;
         act_dp_d     = load ? dp_in    : stg_dp_q;
         act_en_d     = load ? digit_en : stg_en_q;
         pend_d       = 1'b0;
      end
   end

   // Leading-zero mask: disabled digits count as zero, digit 0 always shown
   always_comb begin
      zero_run_c = 1'b1;
      blank_c    = '0;
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
         zero_run_c = zero_run_c & ((act_digits_q[4*i +: 4] == 4'h0) | ~act_en_q[i]);
         if (i != 0) blank_c[i] = blank_lz & zero_run_c;
      end
   end

   // Select the current digit, apply brightness window, build next pin values
   always_comb begin
      sel_nib_c   = '0;
      sel_dp_c    = 1'b0;
      sel_en_c    = 1'b0;
      sel_blank_c = 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_nib_c   = act_digits_q[4*i +: 4];
            sel_dp_c    = act_dp_q[i];
            sel_en_c    = act_en_q[i];
            sel_blank_c = blank_c[i];
         end
      end
      duty_on_c = (PW'(cnt_q) << 4) < ((PW'(duty) + PW'(1)) * SCAN_DIV_P);
      lit_c     = sel_en_c && !sel_blank_c && duty_on_c;
      an_d      = '1;
      seg_d     = 7'h7F;
      dp_n_d    = 1'b1;
      if (lit_c) begin
         an_d   = ~(NUM_DIGITS'(1) << idx_q);
         seg_d  = hex7(sel_nib_c);
         dp_n_d = ~sel_dp_c;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         fd_q         <= 1'b0;
         stg_digits_q <= '0;
         stg_dp_q     <= '0;
         stg_en_q     <= '0;
         pend_q       <= 1'b0;
         act_digits_q <= '0;
         act_dp_q     <= '0;
         act_en_q     <= '0;
         an_q         <= '1;
         seg_q        <= 7'h7F;
         dp_n_q       <= 1'b1;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         fd_q         <= fd_d;
         stg_digits_q <= stg_digits_d;
         stg_dp_q     <= stg_dp_d;
         stg_en_q     <= stg_en_d;
         pend_q       <= pend_d;
         act_digits_q <= act_digits_d;
         act_dp_q     <= act_dp_d;
         act_en_q     <= act_en_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_n_q       <= dp_n_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp_n       = dp_n_q;
   assign frame_done = fd_q;

endmodule
